serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial LSB-first adder, one full-adder cell, WIDTH cycles/op.
// Revision : 1.0
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;

    logic             w_bit;
    logic             w_carry_next;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_next;

    assign w_bit        = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_carry_next = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
    assign w_accept     = start && (r_state != SHIFT);
    assign w_last       = (r_cnt == CW'(WIDTH - 1));
    assign w_acc_next   = {w_bit, r_acc[WIDTH-1:1]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = SHIFT;
            SHIFT:   if (w_last) w_next = DONE;
            DONE:    w_next = start ? SHIFT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            busy    <= (w_next == SHIFT);
            done    <= (w_next == DONE);
            if (w_accept) begin
                r_a     <= a;
                r_b     <= b;
                r_carry <= cin;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else if (r_state == SHIFT) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_carry_next;
                r_acc   <= w_acc_next;
                r_cnt   <= r_cnt + CW'(1);
                // Visible result changes only once the final bit is in.
                if (w_last) begin
                    sum  <= w_acc_next;
                    cout <= w_carry_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// Directed testbench for serial_adder (WIDTH=8).
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one addition; lat counts edges from accepting edge to done edge inclusive.
    task automatic do_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          output logic [7:0] s, output logic co,
                          output int lat, output int bcnt, output bit tmo);
        @(negedge clk);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk); #1;
        lat  = 1;
        bcnt = busy ? 1 : 0;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        tmo = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done) begin
                tmo = 1'b0;
                break;
            end
            if (busy) bcnt++;
        end
        s  = sum;
        co = cout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #2;
        total++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%0d cout=%b, want all 0",
                     busy, done, sum, cout);
        end
        // start while reset is low must not be accepted
        @(negedge clk); start = 1'b1; a = 8'd1; b = 8'd1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_start_ignored: got busy=%b done=%b, want 0 0", busy, done);
        end
        @(negedge clk); start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle_after_release: got busy=%b, want 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s; logic co; int lat; int bcnt; bit tmo;
        do_add(8'd3, 8'd5, 1'b0, s, co, lat, bcnt, tmo);
        total++;
        if (tmo) begin
            bad++;
            $display("FAIL basic_timeout: got no done, want done within 40 cycles");
        end
        total++;
        if (s !== 8'd8 || co !== 1'b0) begin
            bad++;
            $display("FAIL basic_sum: got sum=%0d cout=%b, want 8 0", s, co);
        end
        total++;
        if (lat != 9) begin
            bad++;
            $display("FAIL basic_latency: got %0d edges, want 9", lat);
        end
        total++;
        if (bcnt != 8) begin
            bad++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bcnt);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_busy_in_done: got %b, want 0", busy);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || sum !== 8'd8) begin
            bad++;
            $display("FAIL basic_done_pulse: got done=%b sum=%0d, want 0 8", done, sum);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s; logic co; int lat; int bcnt; bit tmo;
        logic [7:0] va [3] = '{8'd255, 8'd255, 8'd170};
        logic [7:0] vb [3] = '{8'd1,   8'd255, 8'd85};
        logic       vc [3] = '{1'b0,   1'b1,   1'b1};
        logic [7:0] es [3] = '{8'd0,   8'd255, 8'd0};
        logic       ec [3] = '{1'b1,   1'b1,   1'b1};
        for (int i = 0; i < 3; i++) begin
            do_add(va[i], vb[i], vc[i], s, co, lat, bcnt, tmo);
            total++;
            if (tmo || s !== es[i] || co !== ec[i]) begin
                bad++;
                $display("FAIL overflow_%0d: got sum=%0d cout=%b tmo=%b, want %0d %b 0",
                         i, s, co, tmo, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_fa_table();
        logic [7:0] s; logic co; int lat; int bcnt; bit tmo;
        logic [7:0] want;
        for (int i = 0; i < 8; i++) begin
            want = 8'(i[2]) + 8'(i[1]) + 8'(i[0]);
            do_add({7'd0, i[2]}, {7'd0, i[1]}, i[0], s, co, lat, bcnt, tmo);
            total++;
            if (tmo || s !== want || co !== 1'b0) begin
                bad++;
                $display("FAIL fa_table_%0d: got sum=%0d cout=%b tmo=%b, want %0d 0 0",
                         i, s, co, tmo, want);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [7:0] prev; int n; bit seen; bit moved;
        prev  = sum;
        moved = 1'b0;
        @(negedge clk); a = 8'd10; b = 8'd20; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        @(negedge clk); start = 1'b1; a = 8'd1; b = 8'd1; cin = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (sum !== prev) moved = 1'b1;
        end
        total++;
        if (moved) begin
            bad++;
            $display("FAIL ignore_partial_sum: sum changed during SHIFT, want held at %0d", prev);
        end
        total++;
        if (!seen || sum !== 8'd30 || cout !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_result: got sum=%0d cout=%b done_seen=%b, want 30 0 1",
                     sum, cout, seen);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        logic [7:0] s; logic co; int lat; int bcnt; bit tmo; bit seen;
        @(negedge clk); a = 8'd200; b = 8'd100; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || sum !== 8'd0 || done !== 1'b0 || cout !== 1'b0) begin
            bad++;
            $display("FAIL abort_immediate: got busy=%b sum=%0d done=%b cout=%b, want 0 0 0 0",
                     busy, sum, done, cout);
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_no_done: got activity after reset, want idle");
        end
        do_add(8'd7, 8'd9, 1'b0, s, co, lat, bcnt, tmo);
        total++;
        if (tmo || s !== 8'd16 || co !== 1'b0 || lat != 9) begin
            bad++;
            $display("FAIL abort_fresh_op: got sum=%0d cout=%b lat=%0d tmo=%b, want 16 0 9 0",
                     s, co, lat, tmo);
        end
    endtask

    task automatic test_back_to_back();
        int n; bit seen;
        @(negedge clk); a = 8'd3; b = 8'd5; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        a = 8'd100; b = 8'd200; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'd0; b = 8'd0;
        total++;
        if (!seen || busy !== 1'b1 || done !== 1'b0 || sum !== 8'd8) begin
            bad++;
            $display("FAIL b2b_restart: got busy=%b done=%b sum=%0d first_done=%b, want 1 0 8 1",
                     busy, done, sum, seen);
        end
        seen = 1'b0;
        n = 1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen || n != 9 || sum !== 8'd44 || cout !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: got edges=%0d sum=%0d cout=%b seen=%b, want 9 44 1 1",
                     n, sum, cout, seen);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_fa_table();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
